data_memory_responder: RTL and testbench
========================================

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 Parameter: Depth, default 256, number of 32-bit words stored (power of two, >= 4).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: req_valid  input  1  initiator presents a request.
REQ-005 Port: req_ready  output  1  responder accepts the request this cycle.
REQ-006 Port: req_addr  input  32  byte address.
REQ-007 Port: req_write  input  1  1 = store, 0 = load.
REQ-008 Port: req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 Port: req_size  input  2  access size: 0 byte, 1 half, 2 word; 3 is illegal.
REQ-010 Port: req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-011 Port: resp_valid  output  1  a response is pending.
REQ-012 Port: resp_ready  input  1  initiator consumes the response this cycle.
REQ-013 Port: resp_rdata  output  32  load result, already extended; 0 for stores and errors.
REQ-014 Port: resp_error  output  1  request was misaligned, out of range, or used an illegal size.

Function
REQ-015 Handshakes: request accepted when req_valid && req_ready; response consumed when resp_valid && resp_ready.
REQ-016 At most one outstanding response at any time.
REQ-017 Response timing: every accepted request produces exactly one response, with resp_valid asserted on the cycle after acceptance (1-cycle latency).
REQ-018 FSM has two states, IDLE and RESP.
REQ-019 IDLE -> RESP on acceptance.
REQ-020 RESP -> IDLE on consume without a new acceptance.
REQ-021 RESP -> RESP when a response is consumed and a new request is accepted in the same cycle.
REQ-022 req_ready = (state == IDLE) || resp_ready; combinational, with no dependence on req_valid.
REQ-023 Back-to-back throughput: with resp_ready held high, one request per cycle.
REQ-024 Response hold: while resp_valid && !resp_ready, resp_rdata and resp_error stay stable.
REQ-025 Misaligned: half access with addr[0]=1, or word access with addr[1:0]!=0.
REQ-026 Out of range: addr >= 4*Depth.
REQ-027 Error response: a misaligned, out-of-range, or size-3 request sets resp_error=1, resp_rdata=0, and causes no memory write.
REQ-028 Store, byte lanes written:
- byte: lane addr[1:0] only;
- half: lanes addr[1] pair only;
- word: all four lanes.
Unwritten lanes are preserved.
REQ-029 Store commit: a store writes on its acceptance edge; the response has resp_rdata=0, resp_error=0.
REQ-030 Load: data is read from word addr[log2(4*Depth)-1:2] at acceptance, lane-selected by addr[1:0], then extended per req_size/req_unsigned and registered into resp_rdata.
REQ-031 Read-after-write: a load accepted the cycle after a store to the same word returns the new data.
REQ-032 Outside a handshake, req_* inputs are ignored (don't-care).

Reset
REQ-033 rst asserted -> asynchronously: state=IDLE, resp_valid=0, resp_rdata=0, resp_error=0.
REQ-034 Reset mid-operation: a pending response is discarded, and no write occurs on any edge while rst is high.
REQ-035 Memory array contents are not reset.
REQ-036 First acceptance is possible on the first rising edge after rst deasserts.

Structure
REQ-037 Shared package rv32i_defs gains:
- mem_size_t enum (MemByte=0, MemHalf=1, MemWord=2);
- responder state enum (RespIdle, RespPending).
REQ-038 Sub-module load_extend (combinational) performs lane select plus sign/zero extension: inputs word, addr[1:0], size, unsigned_flag; output 32-bit value.
REQ-039 Lane-enable and error decode stay inside data_memory_responder.

Verification
REQ-040 Word round trip: store word 0xDEADBEEF @0x10, then load word @0x10 -> two responses, the second with resp_rdata=0xDEADBEEF, resp_error=0.
REQ-041 Byte extension: store byte 0x80 @0x13 over 0x11223344, then:
- load word @0x10 -> 0x80223344;
- signed byte @0x13 -> 0xFFFFFF80;
- unsigned byte @0x13 -> 0x00000080.
REQ-042 Errors, each -> resp_error=1, rdata=0, and the following word load @0x20 is unchanged:
- half store @0x21 (misaligned);
- word load @0x402 with Depth=256 (misaligned and out of range);
- word load @0x400 with Depth=256 (out of range);
- size=3 store @0x20.
REQ-043 Backpressure: hold resp_ready=0 for 3 cycles after a load -> req_ready=0, response stable for 3 cycles; raise resp_ready together with a new req_valid -> both handshakes occur in the same cycle.
REQ-044 Throughput: 8 consecutive word stores then 8 loads with resp_ready=1 -> 16 responses in 16 consecutive cycles, and the loads return the stored values.
REQ-045 Reset mid-operation: assert rst while resp_valid=1 and resp_ready=0 -> resp_valid drops without waiting for a clock edge, and no extra response appears after release.

Source files
------------

// File: rtl/rv32i_defs_pkg.sv
// Shared RV32I definitions used by the data memory responder.
//   mem_size_t   : access size encoding carried on req_size (3 is illegal, no enumerator).
//   resp_state_t : responder FSM states (idle / response pending).
package rv32i_defs;

  typedef enum logic [1:0] {
    MemByte = 2'd0,
    MemHalf = 2'd1,
    MemWord = 2'd2
  } mem_size_t;

  typedef enum logic {
    RespIdle    = 1'b0,
    RespPending = 1'b1
  } resp_state_t;

endpackage

// File: rtl/data_memory_responder_load_extend.sv
// load_extend: lane select plus sign/zero extension of a loaded word.
//   word          : full 32-bit memory word
//   addr_lo       : byte offset within the word
//   size          : access size (mem_size_t encoding)
//   unsigned_flag : 1 = zero-extend, 0 = sign-extend
//   value         : extended load result
module load_extend
  import rv32i_defs::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        unsigned_flag,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    value = word;
    case (mem_size_t'(size))
      MemByte: value = {{24{byte_sel[7] & ~unsigned_flag}}, byte_sel};
      MemHalf: value = {{16{half_sel[15] & ~unsigned_flag}}, half_sel};
      default: value = word;
    endcase
  end

endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: single-port word memory behind a valid/ready request channel and a
// valid/ready response channel, one outstanding response, 1-cycle latency.
//   clk, rst                 : clock, asynchronous active-high reset
//   req_valid / req_ready    : request handshake
//   req_addr, req_write      : byte address, store (1) or load (0)
//   req_wdata, req_size      : right-aligned store data, access size
//   req_unsigned             : zero-extend loads when set
//   resp_valid / resp_ready  : response handshake
//   resp_rdata, resp_error   : extended load data (0 on store/error), error flag
module data_memory_responder
  import rv32i_defs::*;
#(
  parameter int unsigned Depth = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int unsigned IdxW  = $clog2(Depth);
  localparam int unsigned AddrW = IdxW + 2;

  logic [31:0] mem [Depth];

  resp_state_t state_q, state_d;
  mem_size_t   size;
  logic        accept, consume;
  logic        misaligned, out_of_range, bad_size, req_err, mem_we;
  logic [IdxW-1:0] idx;
  logic [3:0]  lane_en;
  logic [31:0] wdata_rep, rd_word, ld_value;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  assign size   = mem_size_t'(req_size);
  assign idx    = req_addr[AddrW-1:2];
  assign accept = req_valid && req_ready;
  assign consume = resp_valid && resp_ready;

  // Request decode: errors, byte-lane enables and lane-replicated store data.
  always_comb begin
    bad_size     = (req_size == 2'd3);
    out_of_range = |req_addr[31:AddrW];
    misaligned   = ((size == MemHalf) && req_addr[0]) ||
                   ((size == MemWord) && (req_addr[1:0] != 2'b00));
    req_err      = bad_size || out_of_range || misaligned;

    lane_en   = 4'b0000;
    wdata_rep = req_wdata;
    case (size)
      MemByte: begin
        lane_en   = 4'b0001 << req_addr[1:0];
        wdata_rep = {4{req_wdata[7:0]}};
      end
      MemHalf: begin
        lane_en   = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      MemWord: begin
        lane_en   = 4'b1111;
        wdata_rep = req_wdata;
      end
      default: begin
        lane_en   = 4'b0000;
        wdata_rep = req_wdata;
      end
    endcase
  end

  // rst gates the write so a request presented during reset never lands in the array.
  assign mem_we = accept && req_write && !req_err && !rst;

  // Array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  // Asynchronous read so a load right after a store sees the committed data.
  assign rd_word = mem[idx];

  load_extend u_load_extend (
    .word          (rd_word),
    .addr_lo       (req_addr[1:0]),
    .size          (req_size),
    .unsigned_flag (req_unsigned),
    .value         (ld_value)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RespIdle;
    else     state_q <= state_d;
  end

  // FSM next state. Acceptance while pending implies a same-cycle consume.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RespIdle:    if (accept) state_d = RespPending;
      RespPending: if (consume && !accept) state_d = RespIdle;
      default:     state_d = RespIdle;
    endcase
  end

  // FSM outputs. req_ready must not look at req_valid.
  always_comb begin
    resp_valid = (state_q == RespPending);
    req_ready  = (state_q == RespIdle) || resp_ready;
  end

  // Response payload only changes on acceptance, which keeps it stable under backpressure.
  always_comb begin
    rdata_d = rdata_q;
    error_d = error_q;
    if (accept) begin
      error_d = req_err;
      rdata_d = (req_err || req_write) ? 32'h0 : ld_value;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 32'h0;
      error_q <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_error = error_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder (Depth = 256).
module tb_data_memory_responder;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = 2'd2;
  logic        req_unsigned = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_error;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  resp_t exp_q[$];
  resp_t obs_q[$];
  int    obs_cyc[$];

  data_memory_responder #(.Depth(256)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_write    (req_write),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error)
  );

  always #5 clk = ~clk;

  // Record every response that will be consumed on the coming rising edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst && resp_valid && resp_ready) begin
      obs_q.push_back('{rdata: resp_rdata, err: resp_error});
      obs_cyc.push_back(cyc);
    end
  end

  // Present one request from posedge+1 until accepted; push its expected response.
  // Returns at posedge+1 after the acceptance edge with req_valid dropped.
  task automatic send(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      input logic [1:0] sz, input logic uns, input logic [31:0] er,
                      input logic ee, output int waits);
    waits = 0;
    req_valid = 1'b1; req_addr = addr; req_write = wr; req_wdata = wd;
    req_size = sz; req_unsigned = uns;
    @(negedge clk);
    while (!req_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (req_ready) begin
      exp_q.push_back('{rdata: er, err: ee});
    end else begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: req_ready=%b after %0d cycles, want 1", req_ready, waits);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for all expected responses, then resync to posedge+1.
  task automatic drain();
    int n = 0;
    while (obs_q.size() < exp_q.size() && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int w;
    resp_t e, o;
    #1;
    vectors++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_error !== 1'b0 || req_ready !== 1'b1)
    begin
      miscompares++;
      $display("FAIL reset_state: valid=%b rdata=%h err=%b ready=%b, want 0/0/0/1",
               resp_valid, resp_rdata, resp_error, req_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // First edge after release must accept.
    send(32'h20, 1'b1, 32'hCAFEF00D, 2'd2, 1'b0, 32'h0, 1'b0, w);
    vectors++;
    if (w !== 0) begin
      miscompares++;
      $display("FAIL first_accept: waited %0d cycles, want 0", w);
    end
    drain();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o.rdata = 'x; o.err = 1'bx;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      vectors++;
      if (o.rdata !== e.rdata || o.err !== e.err) begin
        miscompares++;
        $display("FAIL reset_store: got rdata=%h err=%b, want rdata=%h err=%b",
                 o.rdata, o.err, e.rdata, e.err);
      end
    end
    obs_cyc.delete();
  endtask

  task automatic test_word_roundtrip();
    int w;
    resp_t e, o;
    send(32'h10, 1'b1, 32'hDEADBEEF, 2'd2, 1'b0, 32'h0, 1'b0, w);
    send(32'h10, 1'b0, 32'h0, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0, w);
    drain();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o.rdata = 'x; o.err = 1'bx;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      vectors++;
      if (o.rdata !== e.rdata || o.err !== e.err) begin
        miscompares++;
        $display("FAIL word_roundtrip: got rdata=%h err=%b, want rdata=%h err=%b",
                 o.rdata, o.err, e.rdata, e.err);
      end
    end
    obs_cyc.delete();
  endtask

  task automatic test_byte_extension();
    int w;
    resp_t e, o;
    send(32'h10, 1'b1, 32'h11223344, 2'd2, 1'b0, 32'h0, 1'b0, w);
    // Upper wdata bits must be ignored for a byte store.
    send(32'h13, 1'b1, 32'hABCDEF80, 2'd0, 1'b0, 32'h0, 1'b0, w);
    send(32'h10, 1'b0, 32'h0, 2'd2, 1'b0, 32'h80223344, 1'b0, w);
    send(32'h13, 1'b0, 32'h0, 2'd0, 1'b0, 32'hFFFFFF80, 1'b0, w);
    send(32'h13, 1'b0, 32'h0, 2'd0, 1'b1, 32'h00000080, 1'b0, w);
    send(32'h12, 1'b0, 32'h0, 2'd1, 1'b0, 32'hFFFF8022, 1'b0, w);
    send(32'h12, 1'b0, 32'h0, 2'd1, 1'b1, 32'h00008022, 1'b0, w);
    send(32'h11, 1'b0, 32'h0, 2'd0, 1'b0, 32'h00000033, 1'b0, w);
    send(32'h10, 1'b0, 32'h0, 2'd1, 1'b0, 32'h00003344, 1'b0, w);
    drain();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o.rdata = 'x; o.err = 1'bx;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      vectors++;
      if (o.rdata !== e.rdata || o.err !== e.err) begin
        miscompares++;
        $display("FAIL byte_extension: got rdata=%h err=%b, want rdata=%h err=%b",
                 o.rdata, o.err, e.rdata, e.err);
      end
    end
    obs_cyc.delete();
  endtask

  task automatic test_errors();
    int w;
    resp_t e, o;
    send(32'h21,  1'b1, 32'h00001234, 2'd1, 1'b0, 32'h0, 1'b1, w);
    send(32'h20,  1'b0, 32'h0,        2'd2, 1'b0, 32'hCAFEF00D, 1'b0, w);
    send(32'h402, 1'b0, 32'h0,        2'd2, 1'b0, 32'h0, 1'b1, w);
    send(32'h20,  1'b0, 32'h0,        2'd2, 1'b0, 32'hCAFEF00D, 1'b0, w);
    send(32'h400, 1'b0, 32'h0,        2'd2, 1'b0, 32'h0, 1'b1, w);
    send(32'h20,  1'b0, 32'h0,        2'd2, 1'b0, 32'hCAFEF00D, 1'b0, w);
    send(32'h20,  1'b1, 32'hFFFFFFFF, 2'd3, 1'b0, 32'h0, 1'b1, w);
    send(32'h20,  1'b0, 32'h0,        2'd2, 1'b0, 32'hCAFEF00D, 1'b0, w);
    // Out-of-range store whose low index bits alias word 0x20.
    send(32'h420, 1'b1, 32'h00000000, 2'd2, 1'b0, 32'h0, 1'b1, w);
    send(32'h20,  1'b0, 32'h0,        2'd2, 1'b0, 32'hCAFEF00D, 1'b0, w);
    drain();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o.rdata = 'x; o.err = 1'bx;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      vectors++;
      if (o.rdata !== e.rdata || o.err !== e.err) begin
        miscompares++;
        $display("FAIL errors: got rdata=%h err=%b, want rdata=%h err=%b",
                 o.rdata, o.err, e.rdata, e.err);
      end
    end
    obs_cyc.delete();
  endtask

  task automatic test_backpressure();
    int w;
    resp_t e, o;
    resp_ready = 1'b0;
    send(32'h10, 1'b0, 32'h0, 2'd2, 1'b0, 32'h80223344, 1'b0, w);
    // Keep a new load presented throughout the stall; it must not be taken.
    req_valid = 1'b1; req_addr = 32'h20; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== 32'h80223344 ||
          resp_error !== 1'b0) begin
        miscompares++;
        $display("FAIL backpressure_hold%0d: valid=%b ready=%b rdata=%h err=%b, want 1/0/80223344/0",
                 k, resp_valid, req_ready, resp_rdata, resp_error);
      end
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b1 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL backpressure_dual: resp_valid=%b req_ready=%b, want 1/1", resp_valid, req_ready);
    end else begin
      exp_q.push_back('{rdata: 32'hCAFEF00D, err: 1'b0});
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o.rdata = 'x; o.err = 1'bx;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      vectors++;
      if (o.rdata !== e.rdata || o.err !== e.err) begin
        miscompares++;
        $display("FAIL backpressure_resp: got rdata=%h err=%b, want rdata=%h err=%b",
                 o.rdata, o.err, e.rdata, e.err);
      end
    end
    obs_cyc.delete();
  endtask

  task automatic test_back_to_back();
    int w;
    int first;
    resp_t e, o;
    logic [31:0] val;
    obs_cyc.delete();
    resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      val = 32'hA5A5A5A5 ^ (32'h01010101 * i);
      send(32'h40 + 4 * i, 1'b1, val, 2'd2, 1'b0, 32'h0, 1'b0, w);
    end
    for (int i = 0; i < 8; i++) begin
      val = 32'hA5A5A5A5 ^ (32'h01010101 * i);
      send(32'h40 + 4 * i, 1'b0, 32'h0, 2'd2, 1'b0, val, 1'b0, w);
    end
    drain();
    vectors++;
    if (obs_cyc.size() !== 16) begin
      miscompares++;
      $display("FAIL throughput_count: got %0d responses, want 16", obs_cyc.size());
    end else begin
      first = obs_cyc[0];
      for (int k = 1; k < 16; k++) begin
        vectors++;
        if (obs_cyc[k] !== first + k) begin
          miscompares++;
          $display("FAIL throughput_cycle%0d: got cycle %0d, want %0d", k, obs_cyc[k], first + k);
        end
      end
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o.rdata = 'x; o.err = 1'bx;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      vectors++;
      if (o.rdata !== e.rdata || o.err !== e.err) begin
        miscompares++;
        $display("FAIL throughput_data: got rdata=%h err=%b, want rdata=%h err=%b",
                 o.rdata, o.err, e.rdata, e.err);
      end
    end
    obs_cyc.delete();
  endtask

  task automatic test_reset_mid();
    int w;
    resp_t e, o;
    resp_ready = 1'b0;
    send(32'h20, 1'b0, 32'h0, 2'd2, 1'b0, 32'hCAFEF00D, 1'b0, w);
    @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_pending: resp_valid=%b, want 1", resp_valid);
    end
    // Assert reset in the low phase, away from any rising edge, with a store presented.
    #2;
    rst = 1'b1;
    req_valid = 1'b1; req_addr = 32'h20; req_write = 1'b1; req_wdata = 32'h0; req_size = 2'd2;
    #1;
    vectors++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_error !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_async: valid=%b rdata=%h err=%b, want 0/0/0",
               resp_valid, resp_rdata, resp_error);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (obs_q.size() !== 0 || resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_extra: %0d responses, resp_valid=%b, want 0/0",
               obs_q.size(), resp_valid);
    end
    obs_q.delete();
    obs_cyc.delete();
    @(posedge clk); #1;
    send(32'h20, 1'b0, 32'h0, 2'd2, 1'b0, 32'hCAFEF00D, 1'b0, w);
    drain();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o.rdata = 'x; o.err = 1'bx;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      vectors++;
      if (o.rdata !== e.rdata || o.err !== e.err) begin
        miscompares++;
        $display("FAIL reset_mid_nowrite: got rdata=%h err=%b, want rdata=%h err=%b",
                 o.rdata, o.err, e.rdata, e.err);
      end
    end
    obs_cyc.delete();
  endtask

  initial begin
    test_reset();
    test_word_roundtrip();
    test_byte_extension();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
